// File: rtl/aux_pkg.sv
// Types and constants shared by the aux bus router and its response FIFOs.
package aux_pkg;

  localparam int AUX_TAG_W  = 9;
  localparam int AUX_DATA_W = 32;

  typedef struct packed {
    logic                  error;
    logic [AUX_TAG_W-1:0]  tag;
    logic [AUX_DATA_W-1:0] data;
  } aux_resp_t;

  localparam aux_resp_t AUX_RESP_ERR = '{error: 1'b1, tag: '0, data: '0};

endpackage

// File: rtl/aux_resp_fifo.sv
// Per-channel response buffer; the extra pointer bit tells full from empty.
module aux_resp_fifo
  import aux_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  aux_resp_t push_data,
  input  logic      pop,
  output aux_resp_t head,
  output logic      empty,
  output logic      full,
  output logic      overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  aux_resp_t   r_mem [DEPTH];
  logic        w_push_ok;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push_ok = push && (!full || pop);
  assign overflow  = push && full && !pop;
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (pop && !empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/aux_router.sv
// Routes CPU aux requests to NUM_TARGETS slaves by base/mask decode and merges
// their buffered responses, plus local decode errors, round-robin.
module aux_router
  import aux_pkg::*;
#(
  parameter int                        NUM_TARGETS = 2,
  parameter logic [NUM_TARGETS*32-1:0] TGT_BASE    = {32'hFFFF0000, 32'hE0000000},
  parameter logic [NUM_TARGETS*32-1:0] TGT_MASK    = {32'hFFFF0000, 32'hFFFF0000},
  parameter int                        TGT_ADDR_W  = 16,
  parameter int                        RESP_DEPTH  = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              cpu_aux_request,
  input  logic                              cpu_aux_write,
  input  logic [31:0]                       cpu_aux_addr,
  input  logic [3:0]                        cpu_aux_wstrb,
  input  logic [31:0]                       cpu_aux_wdata,
  input  logic                              cpu_aux_abort,
  output logic                              cpu_aux_rvalid,
  output logic [31:0]                       cpu_aux_rdata,
  output logic [8:0]                        cpu_aux_rtag,
  output logic                              cpu_aux_rerror,
  output logic [NUM_TARGETS-1:0]            tgt_request,
  output logic [NUM_TARGETS-1:0]            tgt_write,
  output logic [NUM_TARGETS*TGT_ADDR_W-1:0] tgt_addr,
  output logic [NUM_TARGETS*4-1:0]          tgt_wmask,
  output logic [NUM_TARGETS*32-1:0]         tgt_wdata,
  input  logic [NUM_TARGETS-1:0]            tgt_rvalid,
  input  logic [NUM_TARGETS*9-1:0]          tgt_rtag,
  input  logic [NUM_TARGETS*32-1:0]         tgt_rdata,
  output logic                              resp_overflow
);

  localparam int NCH  = NUM_TARGETS + 1;
  localparam int CH_W = $clog2(NCH);

  logic                              w_hit;
  logic [NUM_TARGETS-1:0]            w_sel;
  logic [NUM_TARGETS-1:0]            r_req;
  logic [NUM_TARGETS-1:0]            r_write;
  logic [NUM_TARGETS*TGT_ADDR_W-1:0] r_addr;
  logic [NUM_TARGETS*4-1:0]          r_wmask;
  logic [NUM_TARGETS*32-1:0]         r_wdata;
  logic                              r_err_pend;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if ((cpu_aux_addr & TGT_MASK[i*32 +: 32]) == TGT_BASE[i*32 +: 32]) begin
        w_hit    = 1'b1;
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req      <= '0;
      r_write    <= '0;
      r_addr     <= '0;
      r_wmask    <= '0;
      r_wdata    <= '0;
      r_err_pend <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        if (cpu_aux_request && w_sel[i]) begin
          r_req[i]                            <= 1'b1;
          r_write[i]                          <= cpu_aux_write;
          r_addr[i*TGT_ADDR_W +: TGT_ADDR_W]  <= cpu_aux_addr[TGT_ADDR_W-1:0];
          r_wmask[i*4 +: 4]                   <= cpu_aux_wstrb;
          r_wdata[i*32 +: 32]                 <= cpu_aux_wdata;
        end else begin
          r_req[i]                            <= 1'b0;
          r_write[i]                          <= 1'b0;
          r_addr[i*TGT_ADDR_W +: TGT_ADDR_W]  <= '0;
          r_wmask[i*4 +: 4]                   <= '0;
          r_wdata[i*32 +: 32]                 <= '0;
        end
      end
      r_err_pend <= cpu_aux_request && !cpu_aux_write && !w_hit;
    end
  end

  // The abort arrives one cycle late, so it masks the already-registered strobe.
  assign tgt_request = r_req & ~{NUM_TARGETS{cpu_aux_abort}};
  assign tgt_write   = r_write;
  assign tgt_addr    = r_addr;
  assign tgt_wmask   = r_wmask;
  assign tgt_wdata   = r_wdata;

  aux_resp_t       w_push_data [NCH];
  aux_resp_t       w_head      [NCH];
  logic [NCH-1:0]  w_push;
  logic [NCH-1:0]  w_pop;
  logic [NCH-1:0]  w_empty;
  logic [NCH-1:0]  w_full;
  logic [NCH-1:0]  w_ovf;
  logic            w_unused_full;

  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_cap
    assign w_push[g]      = tgt_rvalid[g];
    assign w_push_data[g] = '{error: 1'b0,
                              tag:   tgt_rtag[g*AUX_TAG_W +: AUX_TAG_W],
                              data:  tgt_rdata[g*AUX_DATA_W +: AUX_DATA_W]};
  end
  assign w_push[NUM_TARGETS]      = r_err_pend && !cpu_aux_abort;
  assign w_push_data[NUM_TARGETS] = AUX_RESP_ERR;
  assign w_unused_full            = ^w_full;

  for (genvar g = 0; g < NCH; g++) begin : g_fifo
    aux_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (w_push[g]),
      .push_data (w_push_data[g]),
      .pop       (w_pop[g]),
      .head      (w_head[g]),
      .empty     (w_empty[g]),
      .full      (w_full[g]),
      .overflow  (w_ovf[g])
    );
  end

  logic [CH_W-1:0] r_last_grant;
  logic            w_grant;
  logic [CH_W-1:0] w_grant_ch;
  aux_resp_t       w_grant_resp;

  always_comb begin
    w_grant      = 1'b0;
    w_grant_ch   = r_last_grant;
    w_grant_resp = '0;
    w_pop        = '0;
    for (int off = 1; off <= NCH; off++) begin
      int ch;
      ch = (int'(r_last_grant) + off) % NCH;
      if (!w_grant && !w_empty[ch]) begin
        w_grant      = 1'b1;
        w_grant_ch   = CH_W'(ch);
        w_grant_resp = w_head[ch];
        w_pop[ch]    = 1'b1;
      end
    end
  end

  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [8:0]  r_rtag;
  logic        r_rerror;
  logic        r_overflow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rtag       <= '0;
      r_rerror     <= 1'b0;
      r_last_grant <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (|w_ovf);
      if (w_grant) begin
        r_rvalid     <= 1'b1;
        r_rdata      <= w_grant_resp.data;
        r_rtag       <= w_grant_resp.tag;
        r_rerror     <= w_grant_resp.error;
        r_last_grant <= w_grant_ch;
      end else begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
        r_rtag   <= '0;
        r_rerror <= 1'b0;
      end
    end
  end

  assign cpu_aux_rvalid = r_rvalid;
  assign cpu_aux_rdata  = r_rdata;
  assign cpu_aux_rtag   = r_rtag;
  assign cpu_aux_rerror = r_rerror;
  assign resp_overflow  = r_overflow;

endmodule

// File: tb/tb_aux_router.sv
// Bench for aux_router: decode vector table, directed corner sequences, and a
// random phase, all cross-checked every cycle by a queue-based response model.
module tb_aux_router;

  localparam int NT = 2;
  localparam int NCH = NT + 1;
  localparam int RD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_aux_request, cpu_aux_write, cpu_aux_abort;
  logic [31:0] cpu_aux_addr, cpu_aux_wdata;
  logic [3:0]  cpu_aux_wstrb;
  logic        cpu_aux_rvalid, cpu_aux_rerror, resp_overflow;
  logic [31:0] cpu_aux_rdata;
  logic [8:0]  cpu_aux_rtag;
  logic [NT-1:0]    tgt_request, tgt_write, tgt_rvalid;
  logic [NT*16-1:0] tgt_addr;
  logic [NT*4-1:0]  tgt_wmask;
  logic [NT*32-1:0] tgt_wdata, tgt_rdata;
  logic [NT*9-1:0]  tgt_rtag;

  always #5 clock = ~clock;

  aux_router #(
    .NUM_TARGETS (NT),
    .TGT_BASE    ({32'hFFFF0000, 32'hE0000000}),
    .TGT_MASK    ({32'hFFFF0000, 32'hFFFF0000}),
    .TGT_ADDR_W  (16),
    .RESP_DEPTH  (RD)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_aux_request(cpu_aux_request), .cpu_aux_write(cpu_aux_write),
    .cpu_aux_addr(cpu_aux_addr), .cpu_aux_wstrb(cpu_aux_wstrb),
    .cpu_aux_wdata(cpu_aux_wdata), .cpu_aux_abort(cpu_aux_abort),
    .cpu_aux_rvalid(cpu_aux_rvalid), .cpu_aux_rdata(cpu_aux_rdata),
    .cpu_aux_rtag(cpu_aux_rtag), .cpu_aux_rerror(cpu_aux_rerror),
    .tgt_request(tgt_request), .tgt_write(tgt_write), .tgt_addr(tgt_addr),
    .tgt_wmask(tgt_wmask), .tgt_wdata(tgt_wdata), .tgt_rvalid(tgt_rvalid),
    .tgt_rtag(tgt_rtag), .tgt_rdata(tgt_rdata), .resp_overflow(resp_overflow)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] base_a [NT] = '{32'hE0000000, 32'hFFFF0000};
  logic [31:0] mask_a [NT] = '{32'hFFFF0000, 32'hFFFF0000};

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NT; i++)
      if ((a & mask_a[i]) == base_a[i]) return i;
    return -1;
  endfunction

  // Reference model: one list per channel, plain round-robin over list heads.
  logic [41:0] mq [NCH][RD];
  int          mcnt [NCH] = '{0, 0, 0};
  int          mlast = 0;
  bit          mpend = 0;
  bit          movf = 0;
  logic        e_rvalid = 0, e_rerr = 0;
  logic [8:0]  e_rtag = 0;
  logic [31:0] e_rdata = 0;
  logic [NT-1:0]    e_req = 0, e_write = 0;
  logic [NT*16-1:0] e_addr = 0;
  logic [NT*4-1:0]  e_wmask = 0;
  logic [NT*32-1:0] e_wdata = 0;

  task automatic mpush(input int c, input logic [41:0] v);
    if (mcnt[c] < RD) begin
      mq[c][mcnt[c]] = v;
      mcnt[c]++;
    end else movf = 1;
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      for (int c = 0; c < NCH; c++) mcnt[c] = 0;
      mlast = 0; mpend = 0; movf = 0;
      e_rvalid = 0; e_rerr = 0; e_rtag = 0; e_rdata = 0;
      e_req = 0; e_write = 0; e_addr = 0; e_wmask = 0; e_wdata = 0;
    end else begin
      int t;
      bit got;
      logic [41:0] h;
      got = 0;
      h = '0;
      for (int off = 1; off <= NCH; off++) begin
        int ch;
        ch = (mlast + off) % NCH;
        if (!got && mcnt[ch] > 0) begin
          got = 1;
          h = mq[ch][0];
          for (int j = 0; j < RD - 1; j++) mq[ch][j] = mq[ch][j+1];
          mcnt[ch]--;
          mlast = ch;
        end
      end
      e_rvalid = got;
      e_rerr   = h[41];
      e_rtag   = h[40:32];
      e_rdata  = h[31:0];
      for (int c = 0; c < NT; c++)
        if (tgt_rvalid[c]) mpush(c, {1'b0, tgt_rtag[c*9 +: 9], tgt_rdata[c*32 +: 32]});
      if (mpend && !cpu_aux_abort) mpush(NT, {1'b1, 41'd0});
      t = decode(cpu_aux_addr);
      mpend = cpu_aux_request && !cpu_aux_write && (t < 0);
      e_req = 0; e_write = 0; e_addr = 0; e_wmask = 0; e_wdata = 0;
      if (cpu_aux_request && t >= 0) begin
        e_req[t]             = 1'b1;
        e_write[t]           = cpu_aux_write;
        e_addr[t*16 +: 16]   = cpu_aux_addr[15:0];
        e_wmask[t*4 +: 4]    = cpu_aux_wstrb;
        e_wdata[t*32 +: 32]  = cpu_aux_wdata;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    chk("m_rvalid", cpu_aux_rvalid, e_rvalid);
    chk("m_rdata", cpu_aux_rdata, e_rdata);
    chk("m_rtag", cpu_aux_rtag, e_rtag);
    chk("m_rerror", cpu_aux_rerror, e_rerr);
    chk("m_overflow", resp_overflow, movf);
    chk("m_tgt_request", tgt_request, e_req & ~{NT{cpu_aux_abort}});
    chk("m_tgt_write", tgt_write, e_write);
    chk("m_tgt_addr", tgt_addr, e_addr);
    chk("m_tgt_wmask", tgt_wmask, e_wmask);
    chk("m_tgt_wdata", tgt_wdata, e_wdata);
  end

  task automatic idle();
    cpu_aux_request = 0; cpu_aux_write = 0; cpu_aux_addr = 0;
    cpu_aux_wstrb = 0; cpu_aux_wdata = 0; cpu_aux_abort = 0;
    tgt_rvalid = 0; tgt_rtag = 0; tgt_rdata = 0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          tgt;
    logic [15:0] taddr;
    logic        err;
  } vec_t;

  vec_t vt [6];

  initial begin
    int seen;
    logic [8:0] prev;
    logic [NT-1:0] ereq;

    vt[0] = '{32'hE0000010, 1'b0, 4'h0,    32'h0,        0, 16'h0010, 1'b0};
    vt[1] = '{32'hFFFF0004, 1'b1, 4'b0011, 32'hAABBCCDD, 1, 16'h0004, 1'b0};
    vt[2] = '{32'hFFFFFFFC, 1'b0, 4'h0,    32'h0,        1, 16'hFFFC, 1'b0};
    vt[3] = '{32'h80000000, 1'b0, 4'h0,    32'h0,       -1, 16'h0000, 1'b1};
    vt[4] = '{32'h80000000, 1'b1, 4'hF,    32'h1,       -1, 16'h0000, 1'b0};
    vt[5] = '{32'hE000ABCD, 1'b1, 4'b1000, 32'h11223344, 0, 16'hABCD, 1'b0};

    idle();
    reset = 1;
    repeat (2) cyc();
    chk("reset_rvalid", cpu_aux_rvalid, 0);
    chk("reset_tgt_request", tgt_request, 0);
    chk("reset_overflow", resp_overflow, 0);
    reset = 0;
    cyc();

    for (int i = 0; i < 6; i++) begin
      cpu_aux_request = 1; cpu_aux_write = vt[i].wr; cpu_aux_addr = vt[i].addr;
      cpu_aux_wstrb = vt[i].strb; cpu_aux_wdata = vt[i].wdata;
      cyc();
      idle();
      ereq = '0;
      if (vt[i].tgt >= 0) ereq[vt[i].tgt] = 1'b1;
      chk("vec_request", tgt_request, ereq);
      if (vt[i].tgt >= 0) begin
        chk("vec_addr", tgt_addr[vt[i].tgt*16 +: 16], vt[i].taddr);
        chk("vec_write", tgt_write[vt[i].tgt], vt[i].wr);
        chk("vec_wmask", tgt_wmask[vt[i].tgt*4 +: 4], vt[i].strb);
        chk("vec_wdata", tgt_wdata[vt[i].tgt*32 +: 32], vt[i].wdata);
      end
      cyc();
      cyc();
      chk("vec_err_rvalid", cpu_aux_rvalid, vt[i].err);
      chk("vec_err_rerror", cpu_aux_rerror, vt[i].err);
      cyc();
    end

    // Single read response: visible two cycles after tgt_rvalid.
    tgt_rvalid = 2'b01; tgt_rtag[8:0] = 9'h05; tgt_rdata[31:0] = 32'h12345678;
    cyc();
    idle();
    chk("lat_early", cpu_aux_rvalid, 0);
    cyc();
    chk("lat_rvalid", cpu_aux_rvalid, 1);
    chk("lat_rtag", cpu_aux_rtag, 9'h05);
    chk("lat_rdata", cpu_aux_rdata, 32'h12345678);
    chk("lat_rerror", cpu_aux_rerror, 0);
    cyc();

    // Write cancelled by abort in the following cycle.
    cpu_aux_request = 1; cpu_aux_write = 1; cpu_aux_addr = 32'hFFFF0004;
    cpu_aux_wstrb = 4'b0011; cpu_aux_wdata = 32'hAABBCCDD;
    cyc();
    idle();
    cpu_aux_abort = 1;
    #1 chk("abort_gate", tgt_request, 0);
    cyc();
    cpu_aux_abort = 0;
    cyc();

    // Simultaneous responses; last grant was channel 0, so target 1 goes first.
    tgt_rvalid = 2'b11; tgt_rtag = {9'h02, 9'h01};
    cyc();
    idle();
    cyc();
    chk("rr_first", cpu_aux_rtag, 9'h02);
    cyc();
    chk("rr_second", cpu_aux_rtag, 9'h01);
    chk("rr_no_overflow", resp_overflow, 0);
    cyc();

    // Aborted unmapped read yields no error response.
    cpu_aux_request = 1; cpu_aux_addr = 32'h80000000;
    cyc();
    idle();
    cpu_aux_abort = 1;
    cyc();
    cpu_aux_abort = 0;
    seen = 0;
    repeat (4) begin cyc(); seen += int'(cpu_aux_rvalid); end
    chk("abort_err_none", seen, 0);

    // Both targets streaming: target 0 overruns its FIFO.
    prev = 9'h0F;
    for (int i = 0; i < 10; i++) begin
      tgt_rvalid = 2'b11;
      tgt_rtag = {9'(9'h20 + i), 9'(9'h10 + i)};
      tgt_rdata = {$urandom, $urandom};
      cyc();
      if (cpu_aux_rvalid && cpu_aux_rtag[8:4] == 5'h01) begin
        chk("ovf_order", cpu_aux_rtag > prev, 1);
        prev = cpu_aux_rtag;
      end
    end
    idle();
    repeat (14) begin
      cyc();
      if (cpu_aux_rvalid && cpu_aux_rtag[8:4] == 5'h01) begin
        chk("ovf_order", cpu_aux_rtag > prev, 1);
        prev = cpu_aux_rtag;
      end
    end
    chk("ovf_sticky", resp_overflow, 1);
    chk("ovf_drained", cpu_aux_rvalid, 0);

    // Reset in the middle of a stream.
    for (int i = 0; i < 3; i++) begin
      tgt_rvalid = 2'b11; tgt_rtag = {9'(9'h40 + i), 9'(9'h30 + i)};
      cyc();
    end
    idle();
    #3 reset = 1;
    #1;
    chk("rst_rvalid", cpu_aux_rvalid, 0);
    chk("rst_rtag", cpu_aux_rtag, 0);
    chk("rst_rdata", cpu_aux_rdata, 0);
    chk("rst_overflow", resp_overflow, 0);
    chk("rst_tgt_request", tgt_request, 0);
    cyc();
    reset = 0;
    seen = 0;
    repeat (6) begin cyc(); seen += int'(cpu_aux_rvalid); end
    chk("rst_no_stale", seen, 0);

    // Random traffic, checked by the model on every cycle.
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      cpu_aux_request = ($urandom_range(0, 2) == 0);
      cpu_aux_write   = 1'($urandom);
      cpu_aux_addr    = (sel == 0) ? {16'hE000, 16'($urandom)} :
                        (sel == 1) ? {16'hFFFF, 16'($urandom)} :
                        (sel == 2) ? {16'h8000, 16'($urandom)} : $urandom;
      cpu_aux_wstrb   = 4'($urandom);
      cpu_aux_wdata   = $urandom;
      cpu_aux_abort   = ($urandom_range(0, 4) == 0);
      tgt_rvalid      = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      tgt_rtag        = 18'($urandom);
      tgt_rdata       = {$urandom, $urandom};
      cyc();
    end
    idle();
    repeat (20) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
